// File: rtl/fir_host_bridge_if.sv
// Bus bundle between the UART byte stream, the FIR filter and fir_host_bridge.
// master = bridge side, slave = UART/filter side.
interface fir_host_bridge_if #(
  parameter int input_width  = 16,
  parameter int output_width = 38,
  parameter int coeff_size   = 64
);
  localparam int AW = (coeff_size > 1) ? $clog2(coeff_size) : 1;

  logic [7:0]                     rx_data;
  logic                           rx_valid;
  logic [7:0]                     tx_data;
  logic                           tx_valid;
  logic                           tx_ready;
  logic [AW-1:0]                  coeff_addr;
  logic signed [input_width-1:0]  coeff;
  logic signed [input_width-1:0]  FIR_Input;
  logic                           Input_Valid;
  logic                           Output_Valid;
  logic signed [output_width-1:0] FIR_Output;

  modport master (
    input  rx_data, rx_valid, tx_ready, coeff_addr, Output_Valid, FIR_Output,
    output tx_data, tx_valid, coeff, FIR_Input, Input_Valid
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, coeff_addr, Output_Valid, FIR_Output,
    input  tx_data, tx_valid, coeff, FIR_Input, Input_Valid
  );
endinterface

// File: rtl/fir_host_bridge.sv
// UART byte protocol bridge to a FIR filter: coefficient loads, sample fire, 5-byte result.
// Define FIR_BRIDGE_ACK_EN to send a 0xA5 byte after a complete coefficient load.
module fir_host_bridge #(
  parameter int input_width  = 16,
  parameter int output_width = 38,
  parameter int coeff_size   = 64
) (
  input  logic clock,
  input  logic reset,
  output logic busy,
  fir_host_bridge_if.master bus
);
  localparam int AW = (coeff_size > 1) ? $clog2(coeff_size) : 1;

  typedef enum logic [3:0] {
    IDLE, COEF_LO, COEF_HI, SAMP_LO, SAMP_HI, FIRE, WAIT, SEND, ACK
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [7:0]             lo_q, lo_d;
  logic [input_width-1:0] fin_q, fin_d;
  logic [39:0]            res_q, res_d;
  logic [2:0]             bidx_q, bidx_d;
  logic                   we;
  logic [input_width-1:0] wdata;
  logic [7:0]             tx_data;
  logic                   tx_valid, in_valid;

  // Coefficient storage is deliberately not reset so a reload survives a reset.
  logic [input_width-1:0] mem_q [coeff_size];

  assign wdata = input_width'({bus.rx_data, lo_q});

  always_ff @(posedge clock) begin
    if (reset && we) mem_q[idx_q] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      fin_q   <= '0;
      res_q   <= '0;
      bidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      fin_q   <= fin_d;
      res_q   <= res_d;
      bidx_q  <= bidx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lo_d     = lo_q;
    fin_d    = fin_q;
    res_d    = res_q;
    bidx_d   = bidx_q;
    we       = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    in_valid = 1'b0;
    case (state_q)
      IDLE: if (bus.rx_valid) begin
        if (bus.rx_data == 8'hC0) begin
          state_d = COEF_LO;
          idx_d   = '0;
        end else if (bus.rx_data == 8'hD0) begin
          state_d = SAMP_LO;
        end
      end
      COEF_LO: if (bus.rx_valid) begin
        lo_d    = bus.rx_data;
        state_d = COEF_HI;
      end
      COEF_HI: if (bus.rx_valid) begin
        we = 1'b1;
        if (idx_q == AW'(coeff_size - 1)) begin
          state_d = ACK;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = COEF_LO;
        end
      end
      SAMP_LO: if (bus.rx_valid) begin
        lo_d    = bus.rx_data;
        state_d = SAMP_HI;
      end
      SAMP_HI: if (bus.rx_valid) begin
        fin_d   = wdata;
        state_d = FIRE;
      end
      FIRE: begin
        in_valid = 1'b1;
        state_d  = WAIT;
      end
      WAIT: if (bus.Output_Valid) begin
        res_d   = 40'($signed(bus.FIR_Output));
        bidx_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = res_q[{bidx_q, 3'b000} +: 8];
        if (bus.tx_ready) begin
          if (bidx_q == 3'd4) state_d = IDLE;
          else                bidx_d  = bidx_q + 3'd1;
        end
      end
      ACK: begin
`ifdef FIR_BRIDGE_ACK_EN
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        if (bus.tx_ready) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx_data     = tx_data;
  assign bus.tx_valid    = tx_valid;
  assign bus.Input_Valid = in_valid;
  assign bus.FIR_Input   = fin_q;
  assign bus.coeff       = mem_q[bus.coeff_addr];
  assign busy            = (state_q != IDLE);
endmodule

// File: tb/tb_fir_host_bridge.sv
// Self-checking bench for fir_host_bridge against a byte-level protocol model.
module tb_fir_host_bridge;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic busy;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [15:0] ref_coef [64];

  fir_host_bridge_if bus ();
  fir_host_bridge dut (.clock(clock), .reset(reset), .busy(busy), .bus(bus.master));

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) tick;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick;
    bus.rx_valid = 1'b0;
  endtask

  // Expected frame: result sign-extended from 38 to 40 bits, low byte first.
  function automatic logic [39:0] ext40(input logic [37:0] v);
    longint s;
    s = longint'(v);
    if (v[37]) s = s - (longint'(1) << 38);
    return 40'(s);
  endfunction

  task automatic collect_frame(input int stall, output logic [39:0] got,
                               output bit stable, output bit tmo);
    logic [7:0] first;
    stable = 1'b1;
    tmo    = 1'b0;
    got    = '0;
    for (int i = 0; i < 5; i++) begin
      int n = 0;
      while (!bus.tx_valid && n < 20) begin tick; n++; end
      if (!bus.tx_valid) begin tmo = 1'b1; return; end
      first = bus.tx_data;
      for (int s = 0; s < stall; s++) begin
        bus.tx_ready = 1'b0;
        tick;
        if (!bus.tx_valid || bus.tx_data !== first) stable = 1'b0;
      end
      got[8*i +: 8] = bus.tx_data;
      bus.tx_ready = 1'b1;
      tick;
      bus.tx_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick; tick;
    tests_run++;
    if ({busy, bus.tx_valid, bus.Input_Valid} !== 3'b000 || bus.tx_data !== 8'h00 ||
        bus.FIR_Input !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_state: busy/txv/iv=%b%b%b tx_data=%h fir_in=%h, required 000 00 0000",
               busy, bus.tx_valid, bus.Input_Valid, bus.tx_data, bus.FIR_Input);
    end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_coef_load;
    send_byte(8'hC0, 1'b0);
    for (int k = 0; k < 64; k++) begin
      logic [15:0] v = 16'(k + 1);
      send_byte(v[7:0], 1'b1);
      send_byte(v[15:8], 1'b1);
      ref_coef[k] = v;
      if (k == 0 || k == 1 || k == 31) begin
        bus.coeff_addr = 6'(k);
        #1;
        tests_run++;
        if (bus.coeff !== v) begin
          tests_failed++;
          $display("FAIL coef_readback_after_write[%0d]: got %h, required %h", k, bus.coeff, v);
        end
      end
    end
`ifdef FIR_BRIDGE_ACK_EN
    bus.tx_ready = 1'b0;
    tick;
    tests_run++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin
      tests_failed++;
      $display("FAIL ack_byte: tx_valid=%b tx_data=%h, required 1 a5", bus.tx_valid, bus.tx_data);
    end
    bus.tx_ready = 1'b1;
    tick;
    bus.tx_ready = 1'b0;
`else
    tests_run++;
    if (bus.tx_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL ack_state: tx_valid=%b busy=%b, required 0 1", bus.tx_valid, busy);
    end
    tick;
`endif
    tests_run++;
    if (busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_return_idle: busy=%b tx_valid=%b, required 0 0", busy, bus.tx_valid);
    end
    bus.coeff_addr = 6'd0; #1;
    tests_run++;
    if (bus.coeff !== 16'h0001) begin
      tests_failed++;
      $display("FAIL coef_addr0: got %h, required 0001", bus.coeff);
    end
    bus.coeff_addr = 6'd63; #1;
    tests_run++;
    if (bus.coeff !== 16'h0040) begin
      tests_failed++;
      $display("FAIL coef_addr63: got %h, required 0040", bus.coeff);
    end
  endtask

  // Runs one sample/result transaction; checks the fire pulse and the frame.
  task automatic run_sample(input string name, input logic [15:0] samp, input logic [37:0] res,
                            input int stall, input bit noise);
    logic [39:0] got;
    bit stable, tmo;
    send_byte(8'hD0, 1'b1);
    send_byte(samp[7:0], 1'b1);
    send_byte(samp[15:8], 1'b1);
    tests_run++;
    if (bus.Input_Valid !== 1'b1 || bus.FIR_Input !== samp) begin
      tests_failed++;
      $display("FAIL %s_fire: iv=%b fir_in=%h, required 1 %h", name, bus.Input_Valid, bus.FIR_Input, samp);
    end
    tick;
    tests_run++;
    if (bus.Input_Valid !== 1'b0 || bus.FIR_Input !== samp || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_wait: iv=%b fir_in=%h busy=%b, required 0 %h 1", name, bus.Input_Valid, bus.FIR_Input, busy, samp);
    end
    if (noise) begin
      send_byte(8'hC0, 1'b0);
      send_byte(8'hD0, 1'b0);
      send_byte(8'h77, 1'b0);
    end
    repeat ($urandom_range(0, 3)) tick;
    bus.FIR_Output   = res;
    bus.Output_Valid = 1'b1;
    tick;
    bus.Output_Valid = 1'b0;
    bus.FIR_Output   = 38'(~res);
    collect_frame(stall, got, stable, tmo);
    tests_run++;
    if (tmo || got !== ext40(res) || !stable || bus.FIR_Input !== samp) begin
      tests_failed++;
      $display("FAIL %s_frame: got %h stable=%0d timeout=%0d, required %h stable=1", name, got, stable, tmo, ext40(res));
    end
    tests_run++;
    if (busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_idle: busy=%b tx_valid=%b, required 0 0", name, busy, bus.tx_valid);
    end
  endtask

  task automatic test_sample_neg_one;
    run_sample("neg_one", 16'h1234, 38'h3F_FFFF_FFFF, 0, 1'b0);
  endtask

  task automatic test_stall;
    run_sample("stall", 16'hBEEF, 38'h00_0012_3456, 3, 1'b0);
  endtask

  task automatic test_ignore;
    send_byte(8'h55, 1'b0);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_idle_byte: busy=%b, required 0", busy);
    end
    bus.FIR_Output = 38'h1; bus.Output_Valid = 1'b1;
    tick;
    bus.Output_Valid = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_idle_ov: busy=%b tx_valid=%b, required 0 0", busy, bus.tx_valid);
    end
    run_sample("wait_noise", 16'h8001, 38'h20_0000_0080, 1, 1'b1);
  endtask

  task automatic test_reset_mid_send;
    send_byte(8'hD0, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    tick;
    bus.FIR_Output = 38'h01_2345_6789; bus.Output_Valid = 1'b1;
    tick;
    bus.Output_Valid = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (3) tick;
    bus.tx_ready = 1'b0;
    reset = 1'b0;
    tick;
    tests_run++;
    if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || bus.tx_data !== 8'h00 || bus.FIR_Input !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_send: txv=%b busy=%b tx_data=%h fir_in=%h, required 0 0 00 0000",
               bus.tx_valid, busy, bus.tx_data, bus.FIR_Input);
    end
    reset = 1'b1;
    tick;
    run_sample("after_reset", 16'h0F0F, 38'h00_0000_00AB, 0, 1'b0);
  endtask

  // Partial load of random values, interrupted by reset; all entries must match the model.
  task automatic test_reset_mid_load;
    int bad = 0;
    int n = $urandom_range(3, 20);
    send_byte(8'hC0, 1'b1);
    for (int k = 0; k < n; k++) begin
      logic [15:0] v = 16'($urandom);
      send_byte(v[7:0], 1'b1);
      send_byte(v[15:8], 1'b1);
      ref_coef[k] = v;
    end
    send_byte(8'hEE, 1'b0);
    bus.rx_data = 8'h99; bus.rx_valid = 1'b1;
    reset = 1'b0;
    tick;
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    tick;
    for (int k = 0; k < 64; k++) begin
      bus.coeff_addr = 6'(k); #1;
      if (bus.coeff !== ref_coef[k]) begin
        bad++;
        if (bad == 1) $display("FAIL coef_after_reset[%0d]: got %h, required %h", k, bus.coeff, ref_coef[k]);
      end
    end
    tests_run++;
    if (bad != 0) tests_failed++;
  endtask

  task automatic test_random;
    for (int t = 0; t < 12; t++) begin
      logic [15:0] s = 16'($urandom);
      logic [37:0] r = 38'({$urandom(), $urandom()});
      run_sample($sformatf("rand%0d", t), s, r, $urandom_range(0, 2), ($urandom_range(0, 1) == 1));
    end
  endtask

  initial begin
    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
    bus.coeff_addr = '0; bus.Output_Valid = 1'b0; bus.FIR_Output = '0;
    test_reset;
    test_coef_load;
    test_sample_neg_one;
    test_stall;
    test_ignore;
    test_reset_mid_send;
    test_reset_mid_load;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/fir_host_bridge.md
FIR_HOST_BRIDGE -- requirements
Module: fir_host_bridge

Interface
REQ-001 Parameter input_width, default 16, sample and coefficient width in bits.
REQ-002 Parameter output_width, default 38, filter result width in bits.
REQ-003 Parameter coeff_size, default 64, number of coefficients; address width = clog2(coeff_size).
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 rx_data  input  8  byte from the UART receiver.
REQ-007 rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-008 tx_data  output  8  byte to the UART transmitter.
REQ-009 tx_valid  output  1  tx_data valid; held until accepted.
REQ-010 tx_ready  input  1  transmitter accepts tx_data when tx_valid and tx_ready are both high.
REQ-011 coeff_addr  input  clog2(coeff_size)  coefficient index driven by the filter's counter_out.
REQ-012 coeff  output  input_width  signed coefficient at coeff_addr.
REQ-013 FIR_Input  output  input_width  signed sample to the filter.
REQ-014 Input_Valid  output  1  one-cycle strobe qualifying FIR_Input.
REQ-015 Output_Valid  input  1  filter result strobe.
REQ-016 FIR_Output  input  output_width  signed filter result.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The block SHALL hold a coeff_size x input_width coefficient register file; coeff = mem[coeff_addr], combinational read.
REQ-019 FSM states: IDLE, COEF_LO, COEF_HI, SAMP_LO, SAMP_HI, FIRE, WAIT, SEND, ACK.
REQ-020 IDLE: rx byte 0xC0 -> COEF_LO with index=0; rx byte 0xD0 -> SAMP_LO; any other byte is dropped and the block stays in IDLE.
REQ-021 COEF_LO: on rx_valid, latch the low byte -> COEF_HI; COEF_HI: on rx_valid, write {rx_data, low byte} to mem[index].
REQ-022 After the COEF_HI write: if index = coeff_size-1 -> ACK, else index+1 -> COEF_LO.
REQ-023 SAMP_LO/SAMP_HI: assemble a little-endian sample; on the SAMP_HI byte, register FIR_Input -> FIRE.
REQ-024 FIRE: assert Input_Valid for exactly 1 cycle -> WAIT; FIR_Input SHALL stay stable from FIRE until the block returns to IDLE.
REQ-025 WAIT: on Output_Valid, capture FIR_Output sign-extended to 40 bits -> SEND with byte index=0.
REQ-026 SEND: tx_data = captured bits [8*i+7:8*i], little-endian, 5 bytes; advance on the tx_valid&tx_ready cycle; after byte 4 is accepted -> IDLE.
REQ-027 tx_valid SHALL NOT deassert and tx_data SHALL NOT change until the byte is accepted.
REQ-028 rx_valid outside IDLE/COEF_*/SAMP_* (FIRE, WAIT, SEND, ACK) SHALL be ignored and the byte dropped.
REQ-029 Output_Valid outside WAIT SHALL be ignored.
REQ-030 coeff_addr reads during a coefficient load SHALL return the updated value from the cycle after the write.

Reset
REQ-031 While reset=0 at a clock edge: state=IDLE, tx_valid=0, tx_data=0, Input_Valid=0, FIR_Input=0, busy=0, byte/coefficient indices=0.
REQ-032 Coefficient register file contents SHALL be unaffected by reset; reset mid-load leaves the already written entries intact.
REQ-033 Reset mid-SEND SHALL drop the remaining bytes; tx_valid=0 from the next cycle.

Configuration
REQ-034 Macro FIR_BRIDGE_ACK_EN defined: ACK state drives tx_data=0xA5 with tx_valid until accepted, then goes to IDLE.
REQ-035 Macro FIR_BRIDGE_ACK_EN undefined: ACK goes to IDLE after 1 cycle with no tx_valid; no ack byte is ever sent.

Verification
REQ-036 Send 0xC0 followed by 128 bytes with coeff k = k+1 -> coeff_addr=0 reads 0x0001 and coeff_addr=63 reads 0x0040; with ACK_EN, one 0xA5 byte is sent.
REQ-037 Send 0xD0,0x34,0x12 -> FIR_Input=0x1234 and a 1-cycle Input_Valid pulse; Output_Valid with FIR_Output=-1 -> tx bytes FF FF FF FF FF.
REQ-038 Send FIR_Output=38'h0_0012_3456 while tx_ready is low for 3 cycles per byte -> 56 34 12 00 00, with tx_data stable while stalled.
REQ-039 Send byte 0x55 in IDLE, then rx bytes during WAIT -> block stays in IDLE for 0x55; the WAIT bytes are dropped and the result frame is unchanged.
REQ-040 Apply reset=0 after tx byte 2 is accepted -> tx_valid=0 and busy=0 next cycle; coefficients readable unchanged; a following 0xD0 transaction completes normally.
